timer_entry_ctrl: RTL and testbench
===================================

// Module: timer_entry_ctrl
// PURPOSE
//  Keypad time-entry and run controller sitting directly upstream of the
//  three-digit timer_ten chain (minutes, seconds-tens, seconds-ones).
//  Collects M:SS digits from the keypad, validates them, loads them into the
//  chain with a one-cycle loadn/en pulse, then issues one-cycle count enables
//  at the tick rate until the chain reports all-zero. Handles pause, resume,
//  door-open and clear.
// PARAMETERS
//  CLK_DIV  100  clk cycles per count tick (>=2); bench overrides to 4
// PORTS
//  clk            in   1  system clock, all state updates on posedge
//  clrn           in   1  async active-low reset
//  key_valid      in   1  one-cycle strobe, key_code valid
//  key_code       in   4  digit 0-9; codes 10-15 ignored
//  start_key      in   1  one-cycle start/resume strobe
//  clear_key      in   1  one-cycle clear/pause strobe
//  door_closed    in   1  level, 1 = door shut
//  all_zero       in   1  AND of every timer_ten zero output
//  data_min       out  4  minutes digit, drives chain data (min)
//  data_sec_tens  out  4  seconds-tens digit, drives chain data
//  data_sec_ones  out  4  seconds-ones digit, drives chain data
//  loadn          out  1  active-low load to all three digits
//  en             out  1  chain enable (load and count)
//  running        out  1  1 while in RUN
//  done           out  1  one-cycle pulse when countdown completes
//  err            out  1  one-cycle pulse on rejected start
// BEHAVIOUR
//  Reset (clrn=0, async): state=IDLE, digits=0, digit count=0, divider=0,
//   loadn=1, en=0, running=0, done=0, err=0. Takes effect mid-operation.
//  States: IDLE, ENTRY, LOAD, RUN, PAUSE, DONE. Outputs are registered.
//  Same-cycle priority: clear_key > start_key > key_valid.
//  IDLE/ENTRY, key_valid with code<=9: shift left
//   (min<=sec_tens, sec_tens<=sec_ones, sec_ones<=code), count++, ->ENTRY.
//   Count saturates at 3; a 4th digit is ignored. Codes >9 are ignored.
//  IDLE/ENTRY, clear_key: digits=0, count=0, ->IDLE.
//  IDLE/ENTRY, start_key: accepted only if door_closed=1, sec_tens<=5, and
//   not all digits 0 -> LOAD. Otherwise err=1 for one cycle; state unchanged.
//  LOAD (exactly 1 cycle): loadn=0, en=1; divider cleared; ->RUN.
//  RUN: running=1; divider counts 0..CLK_DIV-1 and wraps.
//   en=1 for one cycle when divider==CLK_DIV-1, all_zero=0, door_closed=1.
//   all_zero=1 -> DONE, no en that cycle (takes priority over tick).
//   door_closed=0 or clear_key -> PAUSE, no en.
//   Keys and start_key are ignored in RUN.
//  PAUSE: en=0, divider held. start_key with door_closed=1 -> RUN with
//   divider cleared to 0 (start_key with door open -> err pulse).
//   clear_key -> digits=0, count=0, ->IDLE. Keys are ignored.
//  DONE (1 cycle): done=1, digits=0, count=0, ->IDLE.
//  loadn=1 and en=0 in every state except those stated above.
//  Digit outputs are constant outside IDLE/ENTRY/clear/DONE updates.
//  Chain latency: en from this block reaches the timer on the next posedge.
//   all_zero reflects the loaded value in the first RUN cycle.
// TESTING
//  1 keys 1,3,0, door=1, start -> data 1/3/0; loadn=0 & en=1 for exactly 1
//    cycle; running=1 on the next cycle.
//  2 keys 7,5, start -> err=1 for 1 cycle, loadn stays 1, state ENTRY
//    (sec_tens=7>5). Start with no digits -> err pulse.
//  3 CLK_DIV=4, RUN, all_zero=0 -> en high 1 cycle in every 4. Raise
//    all_zero -> no further en; done=1 next cycle; digits read 0.
//  4 door_closed 1->0 in RUN -> PAUSE, en stays 0. Door 1 + start -> RUN;
//    first en 4 cycles later.
//  5 keys 1,2,3,4 -> data 1/2/3 (4th ignored). Key 12 ignored. Clear and key
//    in same cycle -> digits 0, IDLE.
//  6 clrn low mid-RUN (between clk edges) -> all outputs reset immediately;
//    resumes in IDLE after release.

Source files
------------

// File: rtl/timer_entry_ctrl.sv
// Keypad M:SS entry and run controller for a three-digit timer_ten countdown chain.
// Collects and validates digits, loads the chain, then paces count enables until the chain reads zero.
`timescale 1ns/1ps
module timer_entry_ctrl #(
  parameter int CLK_DIV = 100
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       start_key,
  input  logic       clear_key,
  input  logic       door_closed,
  input  logic       all_zero,
  output logic [3:0] data_min,
  output logic [3:0] data_sec_tens,
  output logic [3:0] data_sec_ones,
  output logic       loadn,
  output logic       en,
  output logic       running,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    LOAD,
    RUN,
    PAUSE,
    DONE
  } state_t;

  localparam int                DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_t           state;
  logic [DIV_W-1:0] div;
  logic [1:0]       count;
  logic             start_ok;

  // Seconds-tens above 5 is not a valid M:SS time, and 0:00 has nothing to count.
  assign start_ok = door_closed && (data_sec_tens <= 4'd5) &&
                    ({data_min, data_sec_tens, data_sec_ones} != 12'd0);

  // NOTE: every register here is state, so all assignments are non-blocking; the
  // pulse outputs take their idle value first and are overridden for one cycle below.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state         <= IDLE;
      div           <= '0;
      count         <= 2'd0;
      data_min      <= 4'd0;
      data_sec_tens <= 4'd0;
      data_sec_ones <= 4'd0;
      loadn         <= 1'b1;
      en            <= 1'b0;
      running       <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      loadn <= 1'b1;
      en    <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;

      case (state)
        IDLE, ENTRY: begin
          if (clear_key) begin
            data_min      <= 4'd0;
            data_sec_tens <= 4'd0;
            data_sec_ones <= 4'd0;
            count         <= 2'd0;
            state         <= IDLE;
          end else if (start_key) begin
            if (start_ok) begin
              state <= LOAD;
              loadn <= 1'b0;
              en    <= 1'b1;
              div   <= '0;
            end else begin
              err <= 1'b1;
            end
          end else if (key_valid && (key_code <= 4'd9)) begin
            if (count != 2'd3) begin
              data_min      <= data_sec_tens;
              data_sec_tens <= data_sec_ones;
              data_sec_ones <= key_code;
              count         <= count + 2'd1;
            end
            state <= ENTRY;
          end
        end

        LOAD: begin
          div     <= '0;
          running <= 1'b1;
          state   <= RUN;
        end

        RUN: begin
          // Completion wins over both a pending tick and a pause request.
          if (all_zero) begin
            data_min      <= 4'd0;
            data_sec_tens <= 4'd0;
            data_sec_ones <= 4'd0;
            count         <= 2'd0;
            done          <= 1'b1;
            running       <= 1'b0;
            state         <= DONE;
          end else if (!door_closed || clear_key) begin
            running <= 1'b0;
            state   <= PAUSE;
          end else if (div == DIV_LAST) begin
            div <= '0;
            en  <= 1'b1;
          end else begin
            div <= div + DIV_W'(1);
          end
        end

        PAUSE: begin
          if (clear_key) begin
            data_min      <= 4'd0;
            data_sec_tens <= 4'd0;
            data_sec_ones <= 4'd0;
            count         <= 2'd0;
            state         <= IDLE;
          end else if (start_key) begin
            if (door_closed) begin
              div     <= '0;
              running <= 1'b1;
              state   <= RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_entry_ctrl.sv
// Bench for timer_entry_ctrl: a stand-in timer chain plus a seconds-level reference model,
// driven by directed scenarios followed by randomized keypad/door traffic.
`timescale 1ns/1ps
module tb_timer_entry_ctrl;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       clrn;
  logic       key_valid;
  logic [3:0] key_code;
  logic       start_key;
  logic       clear_key;
  logic       door_closed;
  logic       all_zero;
  logic [3:0] data_min;
  logic [3:0] data_sec_tens;
  logic [3:0] data_sec_ones;
  logic       loadn;
  logic       en;
  logic       running;
  logic       done;
  logic       err;

  timer_entry_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk           (clk),
    .clrn          (clrn),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .start_key     (start_key),
    .clear_key     (clear_key),
    .door_closed   (door_closed),
    .all_zero      (all_zero),
    .data_min      (data_min),
    .data_sec_tens (data_sec_tens),
    .data_sec_ones (data_sec_ones),
    .loadn         (loadn),
    .en            (en),
    .running       (running),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  // Stand-in for the timer_ten chain, held as a plain number of seconds remaining.
  int chain_secs;
  assign all_zero = (chain_secs == 0);

  always @(posedge clk or negedge clrn) begin
    if (!clrn)
      chain_secs <= 0;
    else if (!loadn && en)
      chain_secs <= int'(data_min) * 60 + int'(data_sec_tens) * 10 + int'(data_sec_ones);
    else if (en && chain_secs > 0)
      chain_secs <= chain_secs - 1;
  end

  // Reference model: the entered time is an integer (digits typed so far, base 10),
  // and the tick phase is the number of RUN cycles since the last (re)start.
  typedef enum {M_IDLE, M_ENTRY, M_LOAD, M_RUN, M_PAUSE, M_DONE} mode_t;
  mode_t m_mode;
  int    m_val;
  int    m_cnt;
  int    m_phase;
  bit    x_loadn, x_en, x_done, x_err;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_val   = 0;
    m_cnt   = 0;
    m_phase = 0;
    x_loadn = 1'b1;
    x_en    = 1'b0;
    x_done  = 1'b0;
    x_err   = 1'b0;
  endtask

  task automatic model_step(input bit kv, input int kc, input bit st, input bit cl,
                            input bit dr, input bit az);
    x_loadn = 1'b1;
    x_en    = 1'b0;
    x_done  = 1'b0;
    x_err   = 1'b0;
    case (m_mode)
      M_IDLE, M_ENTRY: begin
        if (cl) begin
          m_val  = 0;
          m_cnt  = 0;
          m_mode = M_IDLE;
        end else if (st) begin
          if (dr && ((m_val / 10) % 10) <= 5 && m_val != 0) begin
            m_mode  = M_LOAD;
            x_loadn = 1'b0;
            x_en    = 1'b1;
          end else begin
            x_err = 1'b1;
          end
        end else if (kv && kc <= 9) begin
          if (m_cnt < 3) begin
            m_val = m_val * 10 + kc;
            m_cnt++;
          end
          m_mode = M_ENTRY;
        end
      end
      M_LOAD: begin
        m_phase = 0;
        m_mode  = M_RUN;
      end
      M_RUN: begin
        if (az) begin
          m_val  = 0;
          m_cnt  = 0;
          x_done = 1'b1;
          m_mode = M_DONE;
        end else if (!dr || cl) begin
          m_mode = M_PAUSE;
        end else if (m_phase % CLK_DIV == CLK_DIV - 1) begin
          x_en    = 1'b1;
          m_phase = 0;
        end else begin
          m_phase++;
        end
      end
      M_PAUSE: begin
        if (cl) begin
          m_val  = 0;
          m_cnt  = 0;
          m_mode = M_IDLE;
        end else if (st) begin
          if (dr) begin
            m_phase = 0;
            m_mode  = M_RUN;
          end else begin
            x_err = 1'b1;
          end
        end
      end
      M_DONE: m_mode = M_IDLE;
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic compare_all();
    check("data_min",      data_min,      m_val / 100);
    check("data_sec_tens", data_sec_tens, (m_val / 10) % 10);
    check("data_sec_ones", data_sec_ones, m_val % 10);
    check("loadn",         loadn,         x_loadn);
    check("en",            en,            x_en);
    check("running",       running,       (m_mode == M_RUN));
    check("done",          done,          x_done);
    check("err",           err,           x_err);
  endtask

  // Called at a negedge: apply inputs, predict, let one posedge pass, compare at the next negedge.
  task automatic cycle(input bit kv, input int kc, input bit st, input bit cl, input bit dr);
    key_valid   = kv;
    key_code    = kc[3:0];
    start_key   = st;
    clear_key   = cl;
    door_closed = dr;
    model_step(kv, kc, st, cl, dr, all_zero);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic press(input int kc);
    cycle(1'b1, kc, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic run_until_idle(input int limit);
    int i;
    i = 0;
    while (m_mode != M_IDLE && i < limit) begin
      cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
      i++;
    end
    check("run_timeout", int'(m_mode), int'(M_IDLE));
  endtask

  initial begin
    clrn        = 1'b0;
    key_valid   = 1'b0;
    key_code    = 4'd0;
    start_key   = 1'b0;
    clear_key   = 1'b0;
    door_closed = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    clrn = 1'b1;

    // Entry, load pulse, full countdown of 1:30.
    press(1); press(3); press(0);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
    check("t1_min", data_min, 1);
    check("t1_tens", data_sec_tens, 3);
    check("t1_ones", data_sec_ones, 0);
    check("t1_loadn", loadn, 0);
    check("t1_en", en, 1);
    idle(1);
    check("t1_running", running, 1);
    check("t1_loadn_after", loadn, 1);
    run_until_idle(1000);

    // Rejected starts: invalid seconds-tens, then nothing entered.
    press(7); press(5);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
    check("t2_err", err, 1);
    check("t2_loadn", loadn, 1);
    idle(1);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
    check("t2_err_empty", err, 1);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);

    // Door opens mid-run, then resume; first tick arrives CLK_DIV cycles after resume.
    press(0); press(1); press(5);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
    idle(10);
    for (int i = 0; i < 6; i++) cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
    check("t4_paused", running, 0);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
    check("t4_err_door", err, 1);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
    idle(3);
    check("t4_no_early_en", en, 0);
    idle(1);
    check("t4_first_en", en, 1);
    run_until_idle(500);

    // Fourth digit and non-digit codes ignored; clear wins over a same-cycle key.
    press(1); press(2); press(3); press(4);
    check("t5_min", data_min, 1);
    check("t5_ones", data_sec_ones, 3);
    press(12);
    cycle(1'b1, 5, 1'b0, 1'b1, 1'b1);
    check("t5_cleared", data_sec_ones, 0);

    // Asynchronous reset between clock edges in the middle of a run.
    press(2); press(0); press(0);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
    idle(10);
    #2;
    clrn = 1'b0;
    #1;
    model_reset();
    check("t6_running", running, 0);
    check("t6_min", data_min, 0);
    compare_all();
    @(negedge clk);
    compare_all();
    clrn = 1'b1;
    press(5);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
    run_until_idle(200);

    // Randomized traffic.
    for (int i = 0; i < 15000; i++) begin
      cycle(($urandom % 5) == 0, int'($urandom % 16), ($urandom % 12) == 0,
            ($urandom % 60) == 0, ($urandom % 40) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
